// File: rtl/register_bank_multiport_pkg.sv
// Shared definitions for the multiport register bank: FSM encoding and default geometry.
package register_bank_multiport_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } bank_state_t;

endpackage

// File: rtl/register_bank_multiport_if.sv
// Pipeline-side bus of the register bank: read ports, debug port, write port and status.
interface register_bank_multiport_if
   import register_bank_multiport_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2
);

   logic [NUM_RD*ADDR_W-1:0] addrRd;
   logic [NUM_RD*DATA_W-1:0] dataRd;
   logic [ADDR_W-1:0]        addrAsync;
   logic [DATA_W-1:0]        outputAsync;
   logic [ADDR_W-1:0]        writeAddr;
   logic [DATA_W-1:0]        writeData;
   logic                     regWrite;
   logic                     clearReq;
   logic                     ready;
   logic                     writeDropped;

   modport master (
      output addrRd, addrAsync, writeAddr, writeData, regWrite, clearReq,
      input  dataRd, outputAsync, ready, writeDropped
   );

   modport slave (
      input  addrRd, addrAsync, writeAddr, writeData, regWrite, clearReq,
      output dataRd, outputAsync, ready, writeDropped
   );

endinterface

// File: rtl/register_bank_multiport_read_port.sv
// One combinational read port: array lookup with clear blanking, zero-register and bypass muxes.
module register_bank_multiport_read_port
   import register_bank_multiport_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] mem [2**ADDR_W],
   input  logic              wr_ok,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);

   // wr_ok already excludes writes during the sweep and writes to a hard-wired r0
   always_comb begin
      data = mem[addr];
      if (!rd_en)
         data = '0;
      else if ((ZERO_REG != 0) && (addr == '0))
         data = '0;
      else if ((BYPASS != 0) && wr_ok && (addr == wr_addr))
         data = wr_data;
   end

endmodule

// File: rtl/register_bank_multiport.sv
// ID-stage register bank: NUM_RD combinational read ports, one write port, a debug read port
// and a sequential zeroing sweep after reset or on clearReq.
module register_bank_multiport
   import register_bank_multiport_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic                    clock,
   input logic                    reset,
   register_bank_multiport_if.slave bus
);

   localparam int DEPTH = 2**ADDR_W;

   bank_state_t       state;
   logic [ADDR_W-1:0] cnt;
   logic              dropped;
   logic              wr_ok;
   logic              rd_en;
   logic [DATA_W-1:0] mem [DEPTH];

   assign rd_en = (state == ST_READY);
   assign wr_ok = rd_en && bus.regWrite &&
                  !((ZERO_REG != 0) && (bus.writeAddr == '0));

   // Control path: only the FSM, sweep counter and sticky flag are reset
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_CLEAR;
         cnt     <= '0;
         dropped <= 1'b0;
      end else begin
         case (state)
            ST_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == '1)
                  state <= ST_READY;
               if (bus.regWrite)
                  dropped <= 1'b1;
            end
            ST_READY: begin
               if (bus.clearReq) begin
                  state <= ST_CLEAR;
                  cnt   <= '0;
               end
            end
            default: begin
               state <= ST_CLEAR;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Array: contents are only ever zeroed by the sweep, never by reset
   always_ff @(posedge clock) begin
      if (state == ST_CLEAR)
         mem[cnt] <= '0;
      else if (wr_ok)
         mem[bus.writeAddr] <= bus.writeData;
   end

   always_comb begin
      bus.outputAsync = mem[bus.addrAsync];
      if ((ZERO_REG != 0) && (bus.addrAsync == '0))
         bus.outputAsync = '0;
   end

   assign bus.ready        = rd_en;
   assign bus.writeDropped = dropped;

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      register_bank_multiport_read_port #(
         .DATA_W  (DATA_W),
         .ADDR_W  (ADDR_W),
         .ZERO_REG(ZERO_REG),
         .BYPASS  (BYPASS)
      ) u_rd (
         .rd_en  (rd_en),
         .addr   (bus.addrRd[k*ADDR_W +: ADDR_W]),
         .mem    (mem),
         .wr_ok  (wr_ok),
         .wr_addr(bus.writeAddr),
         .wr_data(bus.writeData),
         .data   (bus.dataRd[k*DATA_W +: DATA_W])
      );
   end

endmodule

// File: tb/tb_register_bank_multiport.sv
// Directed bench for register_bank_multiport: vector table for read/write/bypass plus clear/reset sequences.
`timescale 1ns/1ps
module tb_register_bank_multiport;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;

   register_bank_multiport_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

   register_bank_multiport #(
      .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [4:0]  ras;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] das;
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra0, input logic [4:0] ra1, input logic [4:0] ras,
                               input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] das);
      vec_t v;
      v.we = we; v.wa = wa; v.wd = wd; v.ra0 = ra0; v.ra1 = ra1; v.ras = ras;
      v.d0 = d0; v.d1 = d1; v.das = das;
      return v;
   endfunction

   // Called at a negedge with ready low; returns rising edges until ready is seen high.
   task automatic sweep(input string tag, input int we_at, input int clr_at,
                        input logic chk_async, input logic [31:0] exp_async, output int edges);
      edges = 0;
      while (!bus.ready && edges < 100) begin
         bus.regWrite = (edges == we_at);
         bus.clearReq = (edges == clr_at);
         #1;
         if (edges == 3) begin
            chk({tag, "_port0_blank"}, bus.dataRd[31:0], 32'h0);
            chk({tag, "_port1_blank"}, bus.dataRd[63:32], 32'h0);
            if (chk_async)
               chk({tag, "_async_raw"}, bus.outputAsync, exp_async);
         end
         @(posedge clock);
         edges++;
         @(negedge clock);
      end
      bus.regWrite = 1'b0;
      bus.clearReq = 1'b0;
   endtask

   initial begin
      int edges;
      n_vec = 0;
      n_err = 0;

      vt[0]  = mk(1, 5'd1,  32'd7,        5'd1,  5'd2,  5'd1,  32'd7,        32'd0,        32'd0);
      vt[1]  = mk(1, 5'd2,  32'd8,        5'd1,  5'd2,  5'd1,  32'd7,        32'd8,        32'd7);
      vt[2]  = mk(1, 5'd3,  32'd9,        5'd3,  5'd2,  5'd2,  32'd9,        32'd8,        32'd8);
      vt[3]  = mk(0, 5'd3,  32'd0,        5'd2,  5'd3,  5'd3,  32'd8,        32'd9,        32'd9);
      vt[4]  = mk(1, 5'd5,  32'hA5,       5'd5,  5'd5,  5'd5,  32'hA5,       32'hA5,       32'd0);
      vt[5]  = mk(0, 5'd5,  32'hA5,       5'd5,  5'd1,  5'd5,  32'hA5,       32'd7,        32'hA5);
      vt[6]  = mk(1, 5'd0,  32'd6,        5'd0,  5'd0,  5'd0,  32'd0,        32'd0,        32'd0);
      vt[7]  = mk(0, 5'd0,  32'd6,        5'd0,  5'd3,  5'd0,  32'd0,        32'd9,        32'd0);
      vt[8]  = mk(1, 5'd30, 32'hFFFFFFFD, 5'd30, 5'd31, 5'd30, 32'hFFFFFFFD, 32'd0,        32'd0);
      vt[9]  = mk(0, 5'd30, 32'd0,        5'd30, 5'd5,  5'd30, 32'hFFFFFFFD, 32'hA5,       32'hFFFFFFFD);
      vt[10] = mk(1, 5'd1,  32'h12345678, 5'd1,  5'd1,  5'd1,  32'h12345678, 32'h12345678, 32'd7);
      vt[11] = mk(0, 5'd1,  32'd0,        5'd1,  5'd2,  5'd1,  32'h12345678, 32'd8,        32'h12345678);
      vt[12] = mk(1, 5'd6,  32'h66,       5'd5,  5'd6,  5'd6,  32'hA5,       32'h66,       32'd0);

      reset         = 1'b0;
      bus.addrRd    = '0;
      bus.addrAsync = '0;
      bus.writeAddr = '0;
      bus.writeData = '0;
      bus.regWrite  = 1'b0;
      bus.clearReq  = 1'b0;

      // Power-on reset and the first sweep
      repeat (3) @(posedge clock);
      #1;
      chk("rst_ready", {31'd0, bus.ready}, 32'd0);
      chk("rst_dropped", {31'd0, bus.writeDropped}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      sweep("init", -1, -1, 1'b0, 32'h0, edges);
      chk("init_sweep_len", edges, 32'd32);
      for (int a = 0; a < 32; a++) begin
         bus.addrRd    = {5'(31 - a), 5'(a)};
         bus.addrAsync = 5'(a);
         #1;
         chk($sformatf("init_zero_r%0d", a),
             bus.dataRd[31:0] | bus.dataRd[63:32] | bus.outputAsync, 32'h0);
      end
      chk("init_dropped", {31'd0, bus.writeDropped}, 32'd0);

      // Table-driven read/write/bypass/zero-register vectors
      for (int i = 0; i < 13; i++) begin
         @(negedge clock);
         bus.regWrite  = vt[i].we;
         bus.writeAddr = vt[i].wa;
         bus.writeData = vt[i].wd;
         bus.addrRd    = {vt[i].ra1, vt[i].ra0};
         bus.addrAsync = vt[i].ras;
         #1;
         chk($sformatf("v%0d_d0", i), bus.dataRd[31:0], vt[i].d0);
         chk($sformatf("v%0d_d1", i), bus.dataRd[63:32], vt[i].d1);
         chk($sformatf("v%0d_async", i), bus.outputAsync, vt[i].das);
         chk($sformatf("v%0d_ready", i), {31'd0, bus.ready}, 32'd1);
         chk($sformatf("v%0d_dropped", i), {31'd0, bus.writeDropped}, 32'd0);
      end

      // clearReq with a simultaneous write; write during sweep is dropped; clearReq in sweep ignored
      @(negedge clock);
      bus.regWrite  = 1'b1;
      bus.writeAddr = 5'd4;
      bus.writeData = 32'h44;
      bus.clearReq  = 1'b1;
      bus.addrRd    = {5'd4, 5'd30};
      bus.addrAsync = 5'd4;
      #1;
      chk("clr_req_bypass", bus.dataRd[63:32], 32'h44);
      chk("clr_req_r30", bus.dataRd[31:0], 32'hFFFFFFFD);
      @(negedge clock);
      bus.regWrite  = 1'b0;
      bus.clearReq  = 1'b0;
      bus.writeAddr = 5'd30;
      bus.writeData = 32'h1111;
      #1;
      chk("clr_ready_low", {31'd0, bus.ready}, 32'd0);
      chk("clr_write_done", bus.outputAsync, 32'h44);
      sweep("clr", 3, 8, 1'b1, 32'h44, edges);
      chk("clr_sweep_len", edges, 32'd32);
      bus.addrAsync = 5'd30;
      #1;
      chk("clr_dropped_set", {31'd0, bus.writeDropped}, 32'd1);
      chk("clr_r30_port", bus.dataRd[31:0], 32'h0);
      chk("clr_r4_port", bus.dataRd[63:32], 32'h0);
      chk("clr_r30_async", bus.outputAsync, 32'h0);

      // Reset mid-sweep restarts it and clears the sticky flag but not the array
      @(negedge clock);
      bus.regWrite  = 1'b1;
      bus.writeAddr = 5'd31;
      bus.writeData = 32'hCAFE0031;
      @(negedge clock);
      bus.regWrite  = 1'b0;
      bus.addrAsync = 5'd31;
      #1;
      chk("r31_written", bus.outputAsync, 32'hCAFE0031);
      chk("dropped_sticky", {31'd0, bus.writeDropped}, 32'd1);
      bus.clearReq = 1'b1;
      @(negedge clock);
      bus.clearReq = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      chk("mid_sweep_r31", bus.outputAsync, 32'hCAFE0031);
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", {31'd0, bus.ready}, 32'd0);
      chk("mid_rst_dropped", {31'd0, bus.writeDropped}, 32'd0);
      chk("mid_rst_array_kept", bus.outputAsync, 32'hCAFE0031);
      repeat (2) @(negedge clock);
      reset = 1'b1;
      sweep("rst", -1, -1, 1'b1, 32'hCAFE0031, edges);
      chk("rst_sweep_len", edges, 32'd32);
      bus.addrRd = {5'd2, 5'd31};
      #1;
      chk("rst_r31_port", bus.dataRd[31:0], 32'h0);
      chk("rst_r2_port", bus.dataRd[63:32], 32'h0);
      chk("rst_r31_async", bus.outputAsync, 32'h0);
      chk("rst_dropped_clear", {31'd0, bus.writeDropped}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
